julia_iter_engine: RTL and testbench



---
 rtl/julia_pkg.sv | 18 +
 rtl/julia_fxmul.sv | 18 +
 rtl/julia_iter_engine.sv | 108 ++++++++++
 tb/tb_julia_iter_engine.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/julia_pkg.sv
// Shared definitions for the Julia-set escape-time iterator.
package julia_pkg;

  localparam int WIDTH_DEF     = 16;
  localparam int FRAC_BITS_DEF = 12;
  localparam int ESCAPE_LIMIT  = 4 << FRAC_BITS_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int esc_limit(input int frac_bits);
    return 4 << frac_bits;
  endfunction

endpackage

// File: rtl/julia_fxmul.sv
// Signed fixed-point multiply: full-width product, arithmetic shift right by FRAC_BITS.
module julia_fxmul #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 12
) (
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] p
);

  logic signed [2*WIDTH-1:0] ax, bx, full;

  assign ax   = a;
  assign bx   = b;
  assign full = ax * bx;
  assign p    = full >>> FRAC_BITS;

endmodule

// File: rtl/julia_iter_engine.sv
// Escape-time iterator z <= z^2 + c, one iteration per clock, until |z|^2 > 4 or MAX_ITER.
module julia_iter_engine
  import julia_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  parameter int MAX_ITER   = 255,
  parameter int ITER_WIDTH = 8
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_Start,
  input  logic [WIDTH-1:0]      i_ZRe,
  input  logic [WIDTH-1:0]      i_ZIm,
  input  logic [WIDTH-1:0]      i_CRe,
  input  logic [WIDTH-1:0]      i_CIm,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic [ITER_WIDTH-1:0] o_Iter,
  output logic                  o_Escaped
);

  localparam int MW = 2 * WIDTH;
  localparam logic signed [MW:0] ESC_LIM = (MW+1)'(esc_limit(FRAC_BITS));
  localparam logic [ITER_WIDTH-1:0] CAP = ITER_WIDTH'(MAX_ITER);

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] zr, zi, cr, ci;
  logic [ITER_WIDTH-1:0]   count;

  logic signed [MW-1:0] zr2, zi2, zri, zr_full, zi_full;
  logic signed [MW:0]   mag;
  logic                 escape, at_cap;

  julia_fxmul #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_rr (.a(zr), .b(zr), .p(zr2));
  julia_fxmul #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_ii (.a(zi), .b(zi), .p(zi2));
  julia_fxmul #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_ri (.a(zr), .b(zi), .p(zri));

  // Magnitude kept wide enough that even the most negative z cannot wrap it.
  assign mag     = $signed({zr2[MW-1], zr2}) + $signed({zi2[MW-1], zi2});
  assign escape  = mag > ESC_LIM;
  assign at_cap  = count == CAP;
  assign zr_full = zr2 - zi2 + cr;
  assign zi_full = (zri <<< 1) + ci;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_Busy    = 1'b0;
    o_Done    = 1'b0;
    case (state)
      IDLE: if (i_Start) state_nxt = ITER;
      ITER: begin
        o_Busy = 1'b1;
        if (escape || at_cap) state_nxt = DONE;
      end
      DONE: begin
        o_Busy    = 1'b1;
        o_Done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      zr        <= '0;
      zi        <= '0;
      cr        <= '0;
      ci        <= '0;
      count     <= '0;
      o_Iter    <= '0;
      o_Escaped <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_Start) begin
          zr    <= i_ZRe;
          zi    <= i_ZIm;
          cr    <= i_CRe;
          ci    <= i_CIm;
          count <= '0;
        end
        ITER: begin
          if (escape) begin
            o_Iter    <= count;
            o_Escaped <= 1'b1;
          end else if (at_cap) begin
            o_Iter    <= CAP;
            o_Escaped <= 1'b0;
          end else begin
            // Truncation to WIDTH is a deliberate two's-complement wrap.
            zr    <= zr_full[WIDTH-1:0];
            zi    <= zi_full[WIDTH-1:0];
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_julia_iter_engine.sv
// Scoreboard bench for julia_iter_engine: directed starts push expected results, a monitor checks o_Done.
module tb_julia_iter_engine;

  logic        i_CLK = 1'b0;
  logic        i_RST = 1'b1;
  logic        i_Start = 1'b0;
  logic [15:0] i_ZRe = '0, i_ZIm = '0, i_CRe = '0, i_CIm = '0;
  logic        o_Busy, o_Done, o_Escaped;
  logic [7:0]  o_Iter;

  julia_iter_engine dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_Start(i_Start),
    .i_ZRe(i_ZRe), .i_ZIm(i_ZIm), .i_CRe(i_CRe), .i_CIm(i_CIm),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Iter(o_Iter), .o_Escaped(o_Escaped)
  );

  always #5 i_CLK = ~i_CLK;

  int cyc = 0;
  always @(posedge i_CLK) cyc <= cyc + 1;

  typedef struct {
    int iter;
    bit esc;
    int e0;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   nchk = 0;
  int   nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: every o_Done pulse must match the oldest outstanding expectation.
  always @(negedge i_CLK) begin
    if (!i_RST && o_Done === 1'b1) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        m_e = q.pop_front();
        chk("iter", o_Iter, m_e.iter);
        chk("escaped", o_Escaped, m_e.esc);
        chk("latency", cyc - m_e.e0, m_e.iter + 1);
        chk("busy_at_done", o_Busy, 1);
      end
    end
  end

  task automatic start(input logic [15:0] zr, zi, cr, ci, output int e0);
    @(negedge i_CLK);
    i_ZRe = zr; i_ZIm = zi; i_CRe = cr; i_CIm = ci;
    i_Start = 1'b1;
    @(posedge i_CLK);
    #1;
    e0 = cyc;
    i_Start = 1'b0;
  endtask

  task automatic issue(input logic [15:0] zr, zi, cr, ci, input int iter, input bit esc);
    int e0;
    start(zr, zi, cr, ci, e0);
    q.push_back('{iter, esc, e0});
    chk("busy_after_accept", o_Busy, 1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (k < 600) begin
      @(negedge i_CLK);
      if (o_Done === 1'b1) break;
      k++;
    end
    if (k == 600) chk("done_timeout", 0, 1);
  endtask

  task automatic run(input logic [15:0] zr, zi, cr, ci, input int iter, input bit esc);
    issue(zr, zi, cr, ci, iter, esc);
    wait_done();
    repeat (2) @(negedge i_CLK);
    chk("iter_held", o_Iter, iter);
    chk("idle_not_busy", o_Busy, 0);
  endtask

  initial begin
    int e0;
    repeat (3) @(negedge i_CLK);
    chk("rst_busy", o_Busy, 0);
    chk("rst_done", o_Done, 0);
    chk("rst_iter", o_Iter, 0);
    chk("rst_escaped", o_Escaped, 0);
    i_RST = 1'b0;

    run(16'h0000, 16'h0000, 16'h0000, 16'h0000, 255, 1'b0);  // origin never escapes
    run(16'h2000, 16'h2000, 16'h0000, 16'h0000, 0,   1'b1);  // |2+2i|^2 = 8
    run(16'h0000, 16'h0000, 16'h1000, 16'h0000, 3,   1'b1);  // 0,1,2,5
    run(16'h0000, 16'h0000, 16'hE000, 16'h0000, 255, 1'b0);  // |z|^2 == 4 exactly
    run(16'hE000, 16'hE000, 16'h0000, 16'h0000, 0,   1'b1);  // -2-2i escapes at once

    // Start mid-run must be ignored.
    issue(16'h0000, 16'h0000, 16'h1000, 16'h0000, 3, 1'b1);
    @(negedge i_CLK);
    i_ZRe = 16'h2000; i_ZIm = 16'h2000; i_CRe = 16'h0000; i_CIm = 16'h0000;
    i_Start = 1'b1;
    @(posedge i_CLK);
    #1 i_Start = 1'b0;
    wait_done();
    // Start held through DONE: the DONE edge ignores it, the next edge accepts.
    i_ZRe = 16'h0000; i_ZIm = 16'h0000; i_CRe = 16'h1000; i_CIm = 16'h0000;
    i_Start = 1'b1;
    @(posedge i_CLK);
    @(posedge i_CLK);
    #1;
    q.push_back('{3, 1'b1, cyc});
    i_Start = 1'b0;
    wait_done();
    repeat (2) @(negedge i_CLK);
    chk("iter_after_done_window", o_Iter, 3);

    // Reset at count 10 of a long run: outputs clear at once, no done pulse.
    start(16'h0000, 16'h0000, 16'h0000, 16'h0000, e0);
    repeat (10) @(posedge i_CLK);
    @(negedge i_CLK);
    i_RST = 1'b1;
    #1;
    chk("midrst_busy", o_Busy, 0);
    chk("midrst_done", o_Done, 0);
    chk("midrst_iter", o_Iter, 0);
    chk("midrst_escaped", o_Escaped, 0);
    repeat (2) @(negedge i_CLK);
    i_RST = 1'b0;
    repeat (3) @(negedge i_CLK);
    chk("post_rst_idle", o_Busy, 0);
    run(16'h0000, 16'h0000, 16'h1000, 16'h0000, 3, 1'b1);

    repeat (3) @(negedge i_CLK);
    if (q.size() != 0) chk("pending_results", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
